// File: rtl/key_chord_scanner.sv
// Eight-key front end: two-flop synchronisers, per-key debounce counters, and a
// registered chord/count with a single-entry valid/ready change event.
module key_chord_scanner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       t0,
  input  logic       t1,
  input  logic       t2,
  input  logic       t3,
  input  logic       t4,
  input  logic       t5,
  input  logic       t6,
  input  logic       t7,
  output logic [7:0] chord,
  output logic [3:0] key_count,
  output logic       chord_valid,
  input  logic       chord_ready,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       raw;
  logic [7:0]       s1;
  logic [7:0]       s2;
  logic [7:0]       stable_nxt;
  logic             chord_changed;
  logic [CNT_W-1:0] cnt     [8];
  logic [CNT_W-1:0] cnt_nxt [8];

  // Packed in chord order so every per-key vector shares one bit index.
  assign raw = {t0, t1, t2, t3, t4, t5, t6, t7};

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // The chord register doubles as the stable (debounced) state of each key.
  always_comb begin
    stable_nxt = chord;
    for (int i = 0; i < 8; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != chord[i]) begin
        if (cnt[i] == TERM_CNT) begin
          stable_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign chord_changed = (stable_nxt != chord);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1          <= '0;
      s2          <= '0;
      chord       <= '0;
      key_count   <= '0;
      chord_valid <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1        <= raw;
      s2        <= s1;
      chord     <= stable_nxt;
      key_count <= popcount8(stable_nxt);
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= cnt_nxt[i];
      end

      // A change landing on the accept edge keeps the event pending.
      if (chord_changed) begin
        chord_valid <= 1'b1;
        if (chord_valid && chord_ready) begin
          overrun <= 1'b0;
        end else if (chord_valid) begin
          overrun <= 1'b1;
        end
      end else if (chord_valid && chord_ready) begin
        chord_valid <= 1'b0;
        overrun     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_chord_scanner.sv
// Directed bench for key_chord_scanner: a vector table for the main handshake
// flow plus hand-written bounce, glitch, same-edge accept and reset sequences.
module tb_key_chord_scanner;

  logic       clk;
  logic       rst_n;
  logic [7:0] t_vec;
  logic [7:0] chord;
  logic [3:0] key_count;
  logic       chord_valid;
  logic       chord_ready;
  logic       overrun;

  int errors;
  int checks;

  typedef struct {
    logic [7:0] t;
    logic       rdy;
    int         cyc;
    logic [7:0] e_chord;
    logic [3:0] e_cnt;
    logic       e_v;
    logic       e_o;
  } vec_t;

  vec_t tbl [13];

  key_chord_scanner #(.DEBOUNCE_CYCLES(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .t0         (t_vec[7]),
    .t1         (t_vec[6]),
    .t2         (t_vec[5]),
    .t3         (t_vec[4]),
    .t4         (t_vec[3]),
    .t5         (t_vec[2]),
    .t6         (t_vec[1]),
    .t7         (t_vec[0]),
    .chord      (chord),
    .key_count  (key_count),
    .chord_valid(chord_valid),
    .chord_ready(chord_ready),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] e_chord, input logic [3:0] e_cnt,
                     input logic e_v, input logic e_o);
    checks++;
    if (chord !== e_chord || key_count !== e_cnt || chord_valid !== e_v || overrun !== e_o) begin
      errors++;
      $display("FAIL %s: got chord=%h count=%0d valid=%b overrun=%b, want chord=%h count=%0d valid=%b overrun=%b",
               name, chord, key_count, chord_valid, overrun, e_chord, e_cnt, e_v, e_o);
    end
  endtask

  task automatic accept(input string name, input logic [7:0] e_chord, input logic [3:0] e_cnt);
    chord_ready = 1'b1;
    step(1);
    chord_ready = 1'b0;
    chk(name, e_chord, e_cnt, 1'b0, 1'b0);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    t_vec       = 8'hFF;
    chord_ready = 1'b0;

    tbl[0]  = '{8'h00, 1'b0,  5, 8'h00, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{8'h80, 1'b0, 17, 8'h00, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{8'h80, 1'b0,  1, 8'h80, 4'd1, 1'b1, 1'b0};
    tbl[3]  = '{8'h80, 1'b1,  1, 8'h80, 4'd1, 1'b0, 1'b0};
    tbl[4]  = '{8'h80, 1'b0,  3, 8'h80, 4'd1, 1'b0, 1'b0};
    tbl[5]  = '{8'hC0, 1'b0, 18, 8'hC0, 4'd2, 1'b1, 1'b0};
    tbl[6]  = '{8'hC1, 1'b0, 18, 8'hC1, 4'd3, 1'b1, 1'b1};
    tbl[7]  = '{8'hC1, 1'b1,  1, 8'hC1, 4'd3, 1'b0, 1'b0};
    tbl[8]  = '{8'hC1, 1'b1,  2, 8'hC1, 4'd3, 1'b0, 1'b0};
    tbl[9]  = '{8'hFF, 1'b0, 18, 8'hFF, 4'd8, 1'b1, 1'b0};
    tbl[10] = '{8'hFF, 1'b1,  1, 8'hFF, 4'd8, 1'b0, 1'b0};
    tbl[11] = '{8'h00, 1'b0, 18, 8'h00, 4'd0, 1'b1, 1'b0};
    tbl[12] = '{8'h00, 1'b1,  1, 8'h00, 4'd0, 1'b0, 1'b0};

    // Reset with every key held down, then release.
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("reset_hold", 8'h00, 4'd0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    step(17);
    chk("reset_release_edge17", 8'h00, 4'd0, 1'b0, 1'b0);
    step(1);
    chk("reset_release_edge18", 8'hFF, 4'd8, 1'b1, 1'b0);
    accept("reset_accept", 8'hFF, 4'd8);
    t_vec = 8'h00;
    step(18);
    chk("release_all", 8'h00, 4'd0, 1'b1, 1'b0);
    accept("release_all_accept", 8'h00, 4'd0);

    for (int i = 0; i < 13; i++) begin
      t_vec       = tbl[i].t;
      chord_ready = tbl[i].rdy;
      step(tbl[i].cyc);
      chk($sformatf("table[%0d]", i), tbl[i].e_chord, tbl[i].e_cnt, tbl[i].e_v, tbl[i].e_o);
    end
    chord_ready = 1'b0;

    // t3 bouncing with 5-cycle phases never reaches the terminal count.
    for (int ph = 0; ph < 8; ph++) begin
      t_vec = (ph % 2 == 0) ? 8'h10 : 8'h00;
      for (int c = 0; c < 5; c++) begin
        step(1);
        chk("bounce", 8'h00, 4'd0, 1'b0, 1'b0);
      end
    end
    t_vec = 8'h10;
    step(17);
    chk("bounce_settle_edge16", 8'h00, 4'd0, 1'b0, 1'b0);
    step(1);
    chk("bounce_settle_edge17", 8'h10, 4'd1, 1'b1, 1'b0);
    accept("bounce_accept", 8'h10, 4'd1);
    t_vec = 8'h00;
    step(18);
    chk("bounce_release", 8'h00, 4'd0, 1'b1, 1'b0);
    accept("bounce_release_accept", 8'h00, 4'd0);

    // t5 high for 15 cycles is one short of acceptance.
    t_vec = 8'h04;
    step(15);
    t_vec = 8'h00;
    for (int c = 0; c < 25; c++) begin
      step(1);
      chk("glitch15", 8'h00, 4'd0, 1'b0, 1'b0);
    end
    t_vec = 8'h04;
    step(17);
    chk("glitch18_pre", 8'h00, 4'd0, 1'b0, 1'b0);
    step(1);
    chk("glitch18_take", 8'h04, 4'd1, 1'b1, 1'b0);
    t_vec = 8'h00;
    accept("glitch18_accept", 8'h04, 4'd1);
    for (int c = 0; c < 16; c++) begin
      step(1);
      chk("glitch18_single_event", 8'h04, 4'd1, 1'b0, 1'b0);
    end
    step(1);
    chk("glitch18_release", 8'h00, 4'd0, 1'b1, 1'b0);
    accept("glitch18_release_accept", 8'h00, 4'd0);

    // Accept on the very edge a new chord settles: event stays pending.
    t_vec = 8'h40;
    step(18);
    chk("same_edge_first", 8'h40, 4'd1, 1'b1, 1'b0);
    t_vec = 8'h41;
    step(17);
    chk("same_edge_pre", 8'h40, 4'd1, 1'b1, 1'b0);
    chord_ready = 1'b1;
    step(1);
    chord_ready = 1'b0;
    chk("same_edge_change", 8'h41, 4'd2, 1'b1, 1'b0);
    step(1);
    chk("same_edge_hold", 8'h41, 4'd2, 1'b1, 1'b0);
    accept("same_edge_accept", 8'h41, 4'd2);
    t_vec = 8'h00;
    step(18);
    chk("same_edge_release", 8'h00, 4'd0, 1'b1, 1'b0);
    accept("same_edge_release_accept", 8'h00, 4'd0);

    // Reset at count 10 of t2's debounce restarts the full latency.
    t_vec = 8'h20;
    step(12);
    chk("mid_rst_before", 8'h00, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_edge", 8'h00, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(17);
    chk("mid_rst_edge17", 8'h00, 4'd0, 1'b0, 1'b0);
    step(1);
    chk("mid_rst_edge18", 8'h20, 4'd1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_chord_scanner.md
Name: key_chord_scanner

Overview:
- Front-end stage that feeds the piano synthesis FSM.
- Synchronises and debounces the eight key inputs t0..t7, then publishes a stable chord vector with a pressed-key count.
- Raises a valid/ready event toward the downstream LISTEN state whenever the debounced chord changes.
- Downstream therefore never samples raw, bouncing switch levels.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised key must differ from its stable value before the change is accepted. Silicon builds use 500000.
- CNT_W, 5: width of each per-key debounce counter. Requires 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- t0..t7  input  1 each  raw key levels; 1 = pressed; asynchronous to clk.
- chord  output  8  debounced chord, ordered {t0,t1,t2,t3,t4,t5,t6,t7} (chord[7]=t0, chord[0]=t7).
- key_count  output  4  number of 1 bits in chord, 0..8.
- chord_valid  output  1  change event pending.
- chord_ready  input  1  downstream accepts the pending event.
- overrun  output  1  a further chord change occurred while an event was still pending.

Behaviour:
- Reset: while rst_n=0 at a posedge, the following clear to 0 at that edge regardless of t inputs:
  - all synchroniser flops, stable bits and counters;
  - chord=0, key_count=0, chord_valid=0, overrun=0.
- Reset asserted mid-debounce discards the partial count.
- Synchroniser: two flops per key (s1, s2). s2 is the only value used by the debounce logic.
- Per-key debounce, evaluated each edge:
  - s2==stable: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: stable<=s2 and cnt<=0.
  - Else: cnt<=cnt+1.
  - Any return to the stable level before the terminal count resets cnt, so glitches shorter than DEBOUNCE_CYCLES are ignored.
- Latency: a clean level change first sampled into s1 at edge k appears on chord after edge k+1+DEBOUNCE_CYCLES.
- chord and key_count are registered and update on the same edge as the stable bits. Keys settling on the same edge produce one combined update.
- Event generation: on any edge where the stable vector changes, chord_valid<=1.
- Handshake:
  - chord_valid stays high until an edge where chord_valid=1 and chord_ready=1. At that edge chord_valid<=0 and overrun<=0.
  - chord_ready while chord_valid=0 has no effect.
- Simultaneous accept and new change on the same edge: the new change wins, so chord_valid stays 1 and overrun stays 0.
- Overrun:
  - A chord change while chord_valid=1 and chord_ready=0 sets overrun<=1. overrun is sticky until the next accept.
  - chord always shows the latest debounced value; there is no queue.
- A press-then-release that is fully debounced before acceptance still leaves chord_valid=1, even though chord ends up equal to its prior value.
- No state machine beyond the per-key counters and the single valid/overrun flag pair.
- No combinational path from t* or chord_ready to any output.

Test Plan (DEBOUNCE_CYCLES=16):
1. Reset: rst_n=0 for 3 edges with t=8'hFF held -> chord=0, key_count=0, chord_valid=0, overrun=0 throughout. After release, chord=8'hFF, count=8 at edge 18 after rst_n rises.
2. Clean press and accept:
   - t0 rises before edge 10 -> chord=8'h80, key_count=1, chord_valid=1 after edge 27.
   - chord_ready=1 for the single edge 30 -> chord_valid=0 after edge 30.
3. Bounce: t3 toggles every 5 cycles for 40 cycles, then holds 1 -> chord stays 0 and chord_valid stays 0 during the bounce. chord=8'h10 17 edges after the first s1 sample of the final high.
4. Glitch boundary: t5 high for exactly 15 cycles -> no change. t5 high for 16+2 cycles -> chord=8'h04 with one chord_valid event.
5. Overrun:
   - Press t1, keep chord_ready=0, then press t7 -> chord=8'h41, key_count=2, overrun=1.
   - One ready edge -> chord_valid=0 and overrun=0.
   - Ready asserted on the same edge as a further change -> chord_valid stays 1.
6. Reset mid-debounce: t2 high, rst_n=0 for 1 edge at cycle 10 of the count -> chord changes only 16 full cycles after reset release.
